// File: rtl/jt51_exp_arb.sv
// Two-port arbiter in front of the shared 32x45 exponent ROM.
// Port 0 streams at full rate; port 1 is single-outstanding and protected by a starvation counter.
module jt51_exp_arb #(
  parameter int AW         = 5,
  parameter int DW         = 45,
  parameter int STARVE_MAX = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ready,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cen,
  input  logic [DW-1:0] rom_exp,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_exp,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_exp,
  input  logic          rsp1_ready
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  // bit 0 = address stage, bit 1 = ROM data stage
  logic [1:0]    vld_pipe;
  logic [1:0]    tag_pipe;
  logic          p1_busy;
  logic [SW-1:0] starve_cnt;

  logic p1_eligible, force1, grant0, grant1;

  assign p1_eligible = req1_valid & ~p1_busy;
  assign force1      = p1_eligible & (starve_cnt == SMAX);
  assign req0_ready  = ~force1;
  assign req1_ready  = ~p1_busy & (force1 | ~req0_valid);
  assign grant0      = req0_valid & req0_ready;
  assign grant1      = ~grant0 & req1_valid & req1_ready;

  assign rom_cen    = cen;
  assign rsp0_valid = vld_pipe[1] & ~tag_pipe[1];
  assign rsp0_exp   = rom_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
      rsp1_valid <= 1'b0;
      rsp1_exp   <= '0;
      p1_busy    <= 1'b0;
      starve_cnt <= '0;
    end else if (cen) begin
      if (grant0)      rom_addr <= req0_addr;
      else if (grant1) rom_addr <= req1_addr;
      vld_pipe <= {vld_pipe[0], grant0 | grant1};
      tag_pipe <= {tag_pipe[0], grant1};

      if (vld_pipe[1] && tag_pipe[1]) begin
        rsp1_valid <= 1'b1;
        rsp1_exp   <= rom_exp;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end

      // busy drops only on the response handshake; ready above uses the old value
      if (grant1)                       p1_busy <= 1'b1;
      else if (rsp1_valid && rsp1_ready) p1_busy <= 1'b0;

      if (grant1 || !p1_eligible)          starve_cnt <= '0;
      else if (grant0 && starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jt51_exp_arb.sv
// Bench for jt51_exp_arb: behavioural ROM, handshake model plus data scoreboard,
// a vector table for port 1 holding and a few directed sequences.
module tb_jt51_exp_arb;

  logic        clk, rst_n, cen;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rom_addr;
  logic        rom_cen, rsp0_valid, rsp1_valid, rsp1_ready;
  logic [44:0] rom_exp, rsp0_exp, rsp1_exp;

  jt51_exp_arb #(.AW(5), .DW(45), .STARVE_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rom_addr(rom_addr), .rom_cen(rom_cen), .rom_exp(rom_exp),
    .rsp0_valid(rsp0_valid), .rsp0_exp(rsp0_exp),
    .rsp1_valid(rsp1_valid), .rsp1_exp(rsp1_exp), .rsp1_ready(rsp1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [44:0] rom_val(input logic [4:0] a);
    return {a, ~a, 3'b101, 32'h9e3779b9 ^ {a, a, a, a, a, a, 2'b00}};
  endfunction

  // ROM latches the address on every enabled edge
  initial begin
    rom_exp = '0;
    forever begin
      @(posedge clk);
      if (rom_cen) rom_exp <= rom_val(rom_addr);
    end
  end

  int n_chk = 0, n_fail = 0, n_rsp0 = 0, edge_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n && cen) edge_cnt++;
  end

  typedef struct { logic [44:0] data; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  bit   m_busy = 0;
  int   m_starve = 0;

  // handshake model + scoreboard; evaluated on the falling edge with stable inputs
  initial begin
    bit elig, frc, e_r0, e_r1, e_v0, e_v1, g0, g1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete(); q1.delete(); m_busy = 0; m_starve = 0;
      end else begin
        elig = req1_valid & ~m_busy;
        frc  = elig && (m_starve == 7);
        e_r0 = ~frc;
        e_r1 = ~m_busy & (frc | ~req0_valid);
        check("req0_ready", 64'(req0_ready), 64'(e_r0));
        check("req1_ready", 64'(req1_ready), 64'(e_r1));
        check("rom_cen", 64'(rom_cen), 64'(cen));
        e_v0 = (q0.size() > 0) && (q0[0].due == edge_cnt);
        check("rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
        if (e_v0) check("rsp0_exp", 64'(rsp0_exp), 64'(q0[0].data));
        e_v1 = (q1.size() > 0) && (q1[0].due <= edge_cnt);
        check("rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
        if (e_v1) check("rsp1_exp", 64'(rsp1_exp), 64'(q1[0].data));
        if (cen) begin
          if (e_v0) begin void'(q0.pop_front()); n_rsp0++; end
          if (e_v1 && rsp1_ready) begin void'(q1.pop_front()); m_busy = 0; end
          g0 = req0_valid & e_r0;
          g1 = !g0 & req1_valid & e_r1;
          if (g0) q0.push_back('{rom_val(req0_addr), edge_cnt + 2});
          if (g1) begin q1.push_back('{rom_val(req1_addr), edge_cnt + 3}); m_busy = 1; end
          if (g1 || !elig)             m_starve = 0;
          else if (g0 && m_starve < 7) m_starve++;
        end
      end
    end
  end

  typedef struct {
    bit cen, v0; logic [4:0] a0; bit v1; logic [4:0] a1; bit rr;
    bit e_r0, e_r1, e_v1;
  } vec_t;
  vec_t tbl[19];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cen = 1; req0_valid = 0; req1_valid = 0; rsp1_ready = 0;
  endtask

  initial begin
    int lows, first_low, base;
    // port 1 alone: accept, hold 10 cycles (two with cen low), release, re-accept
    for (int i = 0; i < 19; i++) tbl[i] = '{1, 0, 0, 1, 6, 0, 1, 0, 0};
    tbl[0]  = '{1, 0, 0, 1, 5, 0, 1, 1, 0};
    for (int i = 3; i < 13; i++) tbl[i].e_v1 = 1;
    tbl[6].cen = 0; tbl[7].cen = 0;
    tbl[13] = '{1, 0, 0, 1, 6, 1, 1, 0, 1};
    tbl[14] = '{1, 0, 0, 1, 6, 0, 1, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 1, 1, 0};

    rst_n = 0; idle(); req0_addr = 0; req1_addr = 0;
    repeat (3) tick();
    check("rst rom_addr", 64'(rom_addr), 0);
    check("rst rsp0_valid", 64'(rsp0_valid), 0);
    check("rst rsp1_valid", 64'(rsp1_valid), 0);
    check("rst rsp1_exp", 64'(rsp1_exp), 0);
    rst_n = 1;
    repeat (3) tick();

    foreach (tbl[i]) begin
      tick();
      cen = tbl[i].cen; req0_valid = tbl[i].v0; req0_addr = tbl[i].a0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; rsp1_ready = tbl[i].rr;
      #1;
      check($sformatf("tbl[%0d].req0_ready", i), 64'(req0_ready), 64'(tbl[i].e_r0));
      check($sformatf("tbl[%0d].req1_ready", i), 64'(req1_ready), 64'(tbl[i].e_r1));
      check($sformatf("tbl[%0d].rsp1_valid", i), 64'(rsp1_valid), 64'(tbl[i].e_v1));
    end
    tick(); idle();

    // port 0 back-to-back stream over all 32 entries
    base = n_rsp0;
    for (int i = 0; i < 32; i++) begin
      tick(); req0_valid = 1; req0_addr = 5'(i);
    end
    tick(); idle();
    repeat (2) tick();
    check("p0 stream count", 64'(n_rsp0 - base), 32);

    // starvation: port 1 forced through after 7 port 0 grants
    lows = 0; first_low = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      req0_valid = 1; req0_addr = 5'(i); req1_valid = 1; req1_addr = 31; rsp1_ready = 0;
      #1;
      if (!req0_ready) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
    end
    check("starve low count", 64'(lows), 1);
    check("starve low index", 64'(first_low), 7);
    tick(); req0_valid = 0; req1_valid = 0; rsp1_ready = 1;
    tick(); idle();
    repeat (3) tick();

    // clock-enable gating with random two-port traffic
    for (int i = 0; i < 40; i++) begin
      tick();
      cen = (i % 4 == 0) || (i % 4 == 3);
      req0_valid = 1'($urandom_range(0, 1)); req0_addr = 5'($urandom_range(0, 31));
      req1_valid = 1'($urandom_range(0, 1)); req1_addr = 5'($urandom_range(0, 31));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
    tick(); idle(); rsp1_ready = 1;
    repeat (8) tick();
    check("cen drain q0", 64'(q0.size()), 0);
    check("cen drain q1", 64'(q1.size()), 0);
    rsp1_ready = 0;

    // reset in the middle of traffic while a port 1 response is held
    tick(); req1_valid = 1; req1_addr = 9;
    for (int i = 0; i < 5; i++) begin
      tick(); req1_valid = 0; req0_valid = 1; req0_addr = 5'(i + 3);
    end
    check("pre-reset rsp1_valid", 64'(rsp1_valid), 1);
    rst_n = 0; req1_valid = 1;
    #1;
    check("mid rst rom_addr", 64'(rom_addr), 0);
    check("mid rst rsp0_valid", 64'(rsp0_valid), 0);
    check("mid rst rsp1_valid", 64'(rsp1_valid), 0);
    check("mid rst rsp1_exp", 64'(rsp1_exp), 0);
    repeat (3) tick();
    rst_n = 1; idle();
    base = n_rsp0;
    repeat (8) tick();
    check("post-reset rsp0 count", 64'(n_rsp0 - base), 0);
    check("post-reset rsp1_valid", 64'(rsp1_valid), 0);
    check("post-reset q0", 64'(q0.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
